// File: rtl/archon_trace_capture_if.sv
// ---------------------------------------------------------------------------
// archon_trace_capture_if
//   Groups the ARCHON debug bus, the capture controls, the trace read port
//   and the capture statistics into one bundle.
//
//   Signals:
//     capture_en, clear              capture control (master -> slave)
//     fsm_state, debug_pc,
//     debug_instr_type_log,
//     debug_entropy_log,
//     debug_stall/flush/lock/hazard  observed debug bus (master -> slave)
//     trace_valid, trace_data        head record (slave -> master)
//     trace_ready                    consumer accept (master -> slave)
//     fill_level, drop_count,
//     overflow                       statistics (slave -> master)
//
//   Handshake: a record transfers on every rising clk edge where
//   trace_valid && trace_ready. While trace_valid is high and trace_ready is
//   low, trace_data holds its value. trace_valid never depends on
//   trace_ready, and trace_data reads as zero whenever trace_valid is low.
//
//   Modports: master = debug source / trace consumer, slave = capture block.
// ---------------------------------------------------------------------------
interface archon_trace_capture_if #(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
);
    localparam int DW = 27 + TS_WIDTH;
    localparam int FW = $clog2(DEPTH) + 1;

    logic          capture_en;
    logic          clear;
    logic [1:0]    fsm_state;
    logic [3:0]    debug_pc;
    logic [2:0]    debug_instr_type_log;
    logic [7:0]    debug_entropy_log;
    logic          debug_stall;
    logic          debug_flush;
    logic          debug_lock;
    logic          debug_hazard;
    logic          trace_valid;
    logic          trace_ready;
    logic [DW-1:0] trace_data;
    logic [FW-1:0] fill_level;
    logic [7:0]    drop_count;
    logic          overflow;

    modport master (
        output capture_en, clear, fsm_state, debug_pc, debug_instr_type_log,
               debug_entropy_log, debug_stall, debug_flush, debug_lock,
               debug_hazard, trace_ready,
        input  trace_valid, trace_data, fill_level, drop_count, overflow
    );

    modport slave (
        input  capture_en, clear, fsm_state, debug_pc, debug_instr_type_log,
               debug_entropy_log, debug_stall, debug_flush, debug_lock,
               debug_hazard, trace_ready,
        output trace_valid, trace_data, fill_level, drop_count, overflow
    );
endinterface

// File: rtl/archon_trace_capture.sv
// ---------------------------------------------------------------------------
// archon_trace_capture
//   Watches the ARCHON debug bus, timestamps every qualifying event (FSM
//   state change, stall/flush/lock rising edge) and buffers one record per
//   cycle in a first-word-fall-through FIFO drained over a valid/ready port.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    archon_trace_capture_if.slave (debug bus, controls, read port,
//            statistics)
//
//   Record, MSB to LSB:
//     timestamp, ev[3:0], pc[3:0], prev_state[1:0], fsm_state[1:0],
//     entropy_log[7:0], instr_type_log[2:0], {stall,flush,lock,hazard}
//
//   DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module archon_trace_capture #(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    archon_trace_capture_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = 27 + TS_WIDTH;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]          fill_q, fill_d;
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [7:0]           drop_q, drop_d;
    logic                 ovf_q, ovf_d;
    logic [1:0]           prev_state_q;
    logic                 prev_stall_q, prev_flush_q, prev_lock_q;
    logic [DW-1:0]        mem_q [DEPTH];

    logic [3:0]           ev;
    logic [DW-1:0]        rec;
    logic                 empty, full, pop, push_req, push_ok, drop_ev;

    always_comb begin
        ev[0] = bus.fsm_state != prev_state_q;
        ev[1] = bus.debug_stall & ~prev_stall_q;
        ev[2] = bus.debug_flush & ~prev_flush_q;
        ev[3] = bus.debug_lock  & ~prev_lock_q;

        rec = {ts_q, ev, bus.debug_pc, prev_state_q, bus.fsm_state,
               bus.debug_entropy_log, bus.debug_instr_type_log,
               bus.debug_stall, bus.debug_flush, bus.debug_lock,
               bus.debug_hazard};

        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop      = !empty && bus.trace_ready;
        push_req = bus.capture_en && (ev != 4'd0);
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_ok  = push_req && (!full || pop);
        drop_ev  = push_req && full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        fill_d   = fill_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        ts_d     = ts_q + TS_WIDTH'(1);
        drop_d   = (drop_ev && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        ovf_d    = ovf_q | drop_ev;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            ts_d     = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            ts_q         <= '0;
            drop_q       <= '0;
            ovf_q        <= 1'b0;
            prev_state_q <= 2'b00;
            prev_stall_q <= 1'b0;
            prev_flush_q <= 1'b0;
            prev_lock_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            ts_q         <= ts_d;
            drop_q       <= drop_d;
            ovf_q        <= ovf_d;
            // Edge trackers follow the bus even when capture is off or
            // clearing, so re-enabling never reports a stale edge.
            prev_state_q <= bus.fsm_state;
            prev_stall_q <= bus.debug_stall;
            prev_flush_q <= bus.debug_flush;
            prev_lock_q  <= bus.debug_lock;
        end
    end

    // Storage needs no reset: empty pointers mask whatever it holds.
    always_ff @(posedge clk) begin
        if (push_ok && !bus.clear) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rec;
        end
    end

    assign bus.trace_valid = !empty;
    assign bus.trace_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.fill_level  = fill_q;
    assign bus.drop_count  = drop_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_archon_trace_capture.sv
module tb_archon_trace_capture;
  localparam int DEPTH = 16;
  localparam int TSW   = 16;
  localparam int DW    = 27 + TSW;
  localparam int FW    = $clog2(DEPTH) + 1;
  localparam int SW    = 1 + DW + FW + 8 + 1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  archon_trace_capture_if #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) bus ();

  archon_trace_capture #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: queue of records plus statistics
  logic [DW-1:0]  exp_q[$];
  logic [TSW-1:0] m_ts;
  logic [7:0]     m_drop;
  logic           m_ovf;
  logic [1:0]     m_prev_state;
  logic           m_prev_stall, m_prev_flush, m_prev_lock;

  function automatic void model_reset();
    exp_q.delete();
    m_ts = '0; m_drop = '0; m_ovf = 1'b0;
    m_prev_state = 2'b00; m_prev_stall = 1'b0; m_prev_flush = 1'b0; m_prev_lock = 1'b0;
  endfunction

  function automatic logic [SW-1:0] exp_status();
    logic [DW-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : {DW{1'b0}};
    return {exp_q.size() != 0, head, FW'(exp_q.size()), m_drop, m_ovf};
  endfunction

  function automatic logic [SW-1:0] dut_status();
    return {bus.trace_valid, bus.trace_data, bus.fill_level, bus.drop_count, bus.overflow};
  endfunction

  // driver: one clock cycle, model advanced from the inputs seen at the edge
  task automatic step();
    logic [3:0]    ev;
    logic [DW-1:0] rec;
    bit            do_pop, do_push;
    ev[0] = bus.fsm_state != m_prev_state;
    ev[1] = bus.debug_stall && !m_prev_stall;
    ev[2] = bus.debug_flush && !m_prev_flush;
    ev[3] = bus.debug_lock && !m_prev_lock;
    rec = {m_ts, ev, bus.debug_pc, m_prev_state, bus.fsm_state, bus.debug_entropy_log,
           bus.debug_instr_type_log, bus.debug_stall, bus.debug_flush, bus.debug_lock,
           bus.debug_hazard};
    do_pop  = (exp_q.size() != 0) && bus.trace_ready;
    do_push = bus.capture_en && (ev != 4'd0);
    @(posedge clk);
    if (bus.clear) begin
      exp_q.delete();
      m_ts = '0; m_drop = '0; m_ovf = 1'b0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(rec);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
      end
      m_ts = m_ts + 1'b1;
    end
    m_prev_state = bus.fsm_state;
    m_prev_stall = bus.debug_stall;
    m_prev_flush = bus.debug_flush;
    m_prev_lock  = bus.debug_lock;
    #1;
  endtask

  task automatic drive_idle();
    bus.capture_en = 1'b1; bus.clear = 1'b0; bus.fsm_state = 2'b00; bus.debug_pc = 4'h0;
    bus.debug_instr_type_log = 3'd0; bus.debug_entropy_log = 8'h00;
    bus.debug_stall = 1'b0; bus.debug_flush = 1'b0; bus.debug_lock = 1'b0;
    bus.debug_hazard = 1'b0; bus.trace_ready = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_status() !== {SW{1'b0}}) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_status(), {SW{1'b0}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (dut_status() !== exp_status()) begin
        errors++; $display("FAIL idle_cycle%0d: got %h expected %h", i, dut_status(), exp_status());
      end
    end
    checks++;
    if (bus.trace_valid !== 1'b0 || bus.fill_level !== '0) begin
      errors++; $display("FAIL idle_empty: valid=%b fill=%0d expected 0/0", bus.trace_valid, bus.fill_level);
    end
  endtask

  task automatic test_first_event();
    logic [DW-1:0] d;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    repeat (12) step();
    bus.fsm_state = 2'b01; bus.debug_pc = 4'h3; bus.debug_entropy_log = 8'hC8;
    bus.trace_ready = 1'b1;
    step();
    d = bus.trace_data;
    checks++;
    if (bus.trace_valid !== 1'b1 || d[42:27] !== 16'd12 || d[26:23] !== 4'b0001 ||
        d[22:19] !== 4'h3 || d[18:17] !== 2'b00 || d[16:15] !== 2'b01 || d[14:7] !== 8'hC8) begin
      errors++; $display("FAIL first_record: got valid=%b data=%h expected ts=12 ev=1 pc=3 prev=0 st=1 ent=c8",
                         bus.trace_valid, d);
    end
    checks++;
    if (dut_status() !== exp_status()) begin
      errors++; $display("FAIL first_model: got %h expected %h", dut_status(), exp_status());
    end
    step();
    checks++;
    if (bus.trace_valid !== 1'b0) begin
      errors++; $display("FAIL first_one_cycle: valid=%b expected 0", bus.trace_valid);
    end
  endtask

  task automatic test_multi_cause();
    logic [DW-1:0] d;
    bus.trace_ready = 1'b1;
    bus.debug_stall = 1'b1; bus.debug_flush = 1'b1; bus.fsm_state = 2'b10;
    step();
    d = bus.trace_data;
    checks++;
    if (bus.trace_valid !== 1'b1 || d[26:23] !== 4'b0111 || d[3:2] !== 2'b11) begin
      errors++; $display("FAIL multi_cause: got valid=%b ev=%b expected 1/0111", bus.trace_valid, d[26:23]);
    end
    bus.debug_stall = 1'b0; bus.debug_flush = 1'b0;
    step();
    checks++;
    if (dut_status() !== exp_status() || bus.trace_valid !== 1'b0) begin
      errors++; $display("FAIL multi_single: got %h expected %h", dut_status(), exp_status());
    end
  endtask

  task automatic test_overflow_drain();
    logic [TSW-1:0] last_ts;
    int             popped;
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.fsm_state = bus.fsm_state + 2'd1;
      bus.debug_entropy_log = 8'($urandom);
      step();
    end
    checks++;
    if (bus.fill_level !== FW'(16) || bus.drop_count !== 8'd4 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_stats: fill=%0d drop=%0d ovf=%b expected 16/4/1",
                         bus.fill_level, bus.drop_count, bus.overflow);
    end
    bus.trace_ready = 1'b1;
    popped = 0;
    last_ts = '0;
    for (int i = 0; i < 18; i++) begin
      if (bus.trace_valid === 1'b1) begin
        checks++;
        if (popped != 0 && bus.trace_data[42:27] <= last_ts) begin
          errors++; $display("FAIL drain_ts_order: got %0d after %0d", bus.trace_data[42:27], last_ts);
        end
        last_ts = bus.trace_data[42:27];
        popped++;
      end
      step();
      checks++;
      if (dut_status() !== exp_status()) begin
        errors++; $display("FAIL drain%0d: got %h expected %h", i, dut_status(), exp_status());
      end
    end
    checks++;
    if (popped != 16 || bus.trace_valid !== 1'b0) begin
      errors++; $display("FAIL drain_count: got %0d records valid=%b expected 16/0", popped, bus.trace_valid);
    end
  endtask

  task automatic test_full_pop();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.fsm_state = bus.fsm_state + 2'd1;
      step();
    end
    bus.trace_ready = 1'b1;
    bus.fsm_state = bus.fsm_state + 2'd1;
    step();
    checks++;
    if (bus.fill_level !== FW'(16) || bus.drop_count !== 8'd4 || dut_status() !== exp_status()) begin
      errors++; $display("FAIL full_pop: fill=%0d drop=%0d got %h expected %h",
                         bus.fill_level, bus.drop_count, dut_status(), exp_status());
    end
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (dut_status() !== exp_status() || bus.trace_valid !== 1'b0) begin
      errors++; $display("FAIL full_pop_drain: got %h expected %h", dut_status(), exp_status());
    end
  endtask

  task automatic test_clear_reset();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.fsm_state = bus.fsm_state + 2'd1;
      step();
    end
    checks++;
    if (bus.fill_level !== FW'(5)) begin
      errors++; $display("FAIL clear_prefill: fill=%0d expected 5", bus.fill_level);
    end
    bus.clear = 1'b1;
    bus.fsm_state = bus.fsm_state + 2'd1;
    bus.trace_ready = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++;
    if (bus.fill_level !== '0 || bus.overflow !== 1'b0 || dut_status() !== exp_status()) begin
      errors++; $display("FAIL clear: fill=%0d ovf=%b got %h expected %h",
                         bus.fill_level, bus.overflow, dut_status(), exp_status());
    end
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.debug_lock = ~bus.debug_lock;
      bus.fsm_state = bus.fsm_state + 2'd1;
      step();
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_status() !== {SW{1'b0}}) begin
      errors++; $display("FAIL async_reset: got %h expected 0", dut_status());
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dut_status() !== exp_status()) begin
        errors++; $display("FAIL post_reset%0d: got %h expected %h", i, dut_status(), exp_status());
      end
    end
  endtask

  task automatic test_drop_saturate();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 290; i++) begin
      bus.fsm_state = bus.fsm_state + 2'd1;
      step();
    end
    checks++;
    if (bus.drop_count !== 8'hFF || dut_status() !== exp_status()) begin
      errors++; $display("FAIL drop_saturate: drop=%0d got %h expected %h",
                         bus.drop_count, dut_status(), exp_status());
    end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.capture_en = ($urandom_range(0, 9) != 0);
      bus.clear = ($urandom_range(0, 49) == 0);
      bus.fsm_state = 2'($urandom);
      bus.debug_pc = 4'($urandom);
      bus.debug_instr_type_log = 3'($urandom);
      bus.debug_entropy_log = 8'($urandom);
      bus.debug_stall = ($urandom_range(0, 2) == 0);
      bus.debug_flush = ($urandom_range(0, 3) == 0);
      bus.debug_lock = ($urandom_range(0, 4) == 0);
      bus.debug_hazard = 1'($urandom);
      bus.trace_ready = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if (dut_status() !== exp_status()) begin
        errors++; $display("FAIL random%0d: got %h expected %h", i, dut_status(), exp_status());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_event();
    test_multi_cause();
    test_overflow_drain();
    test_full_pop();
    test_clear_reset();
    test_drop_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
